// File: rtl/alu_cmd_driver.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_driver
// Purpose  : Initiator side of the ALU operand/result interface. Accepts one
//            command at a time over a valid/ready channel, registers the
//            operands onto the combinational ALU inputs, holds them for a
//            multicycle settle window and captures result/carry into a
//            registered response channel with tag and error flag.
// Ports    : clk, rst (async, active-high)
//            cmd_valid/cmd_ready, cmd_opcode, cmd_a, cmd_b, cmd_shift, cmd_tag
//            alu_opcode, alu_input1, alu_input2, alu_shiftValue (to ALU)
//            alu_result, alu_carry (from ALU)
//            rsp_valid/rsp_ready, rsp_result, rsp_carry, rsp_tag, rsp_err
//            busy
// Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_driver #(
    parameter int WIDTH      = 128,
    parameter int SHIFT_W    = 5,
    parameter int TAG_W      = 4,
    parameter int SETTLE     = 2,
    parameter int DIV_SETTLE = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [3:0]         cmd_opcode,
    input  logic [WIDTH-1:0]   cmd_a,
    input  logic [WIDTH-1:0]   cmd_b,
    input  logic [SHIFT_W-1:0] cmd_shift,
    input  logic [TAG_W-1:0]   cmd_tag,
    output logic [3:0]         alu_opcode,
    output logic [WIDTH-1:0]   alu_input1,
    output logic [WIDTH-1:0]   alu_input2,
    output logic [SHIFT_W-1:0] alu_shiftValue,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_carry,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_result,
    output logic               rsp_carry,
    output logic [TAG_W-1:0]   rsp_tag,
    output logic               rsp_err,
    output logic               busy
);

    localparam int CNT_W = (DIV_SETTLE > 1) ? $clog2(DIV_SETTLE) : 1;

    localparam logic [CNT_W-1:0] C_SET_LOAD = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] C_DIV_LOAD = CNT_W'(DIV_SETTLE - 1);

    localparam logic [3:0] C_OP_ADD = 4'd0;
    localparam logic [3:0] C_OP_SUB = 4'd1;
    localparam logic [3:0] C_OP_DIV = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               busy_q, busy_d;
    logic [3:0]         alu_opcode_q, alu_opcode_d;
    logic [WIDTH-1:0]   alu_input1_q, alu_input1_d;
    logic [WIDTH-1:0]   alu_input2_q, alu_input2_d;
    logic [SHIFT_W-1:0] alu_shift_q, alu_shift_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               err_q, err_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   rsp_result_q, rsp_result_d;
    logic               rsp_carry_q, rsp_carry_d;
    logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
    logic               rsp_err_q, rsp_err_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_opcode_d = alu_opcode_q;
        alu_input1_d = alu_input1_q;
        alu_input2_d = alu_input2_q;
        alu_shift_d  = alu_shift_q;
        tag_d        = tag_q;
        err_d        = err_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_tag_d    = rsp_tag_q;
        rsp_err_d    = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    alu_opcode_d = cmd_opcode;
                    alu_input1_d = cmd_a;
                    alu_input2_d = cmd_b;
                    alu_shift_d  = cmd_shift;
                    tag_d        = cmd_tag;
                    // Error is decided from the command itself so it does not
                    // depend on anything the ALU returns.
                    err_d        = ((cmd_opcode == C_OP_DIV) && (cmd_b == '0)) ||
                                   cmd_opcode[3];
                    cnt_d        = (cmd_opcode == C_OP_DIV) ? C_DIV_LOAD : C_SET_LOAD;
                    state_d      = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    // Illegal opcodes (8-15) never expose whatever the ALU drives.
                    rsp_result_d = alu_opcode_q[3] ? '0 : alu_result;
                    rsp_carry_d  = ((alu_opcode_q == C_OP_ADD) ||
                                    (alu_opcode_q == C_OP_SUB)) ? alu_carry : 1'b0;
                    rsp_err_d    = err_q;
                    rsp_tag_d    = tag_q;
                    rsp_valid_d  = 1'b1;
                    state_d      = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Both flags are registered copies of the next state so they line up
        // with the state register without any output decode.
        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            cmd_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            alu_opcode_q <= '0;
            alu_input1_q <= '0;
            alu_input2_q <= '0;
            alu_shift_q  <= '0;
            tag_q        <= '0;
            err_q        <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_tag_q    <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cmd_ready_q  <= cmd_ready_d;
            busy_q       <= busy_d;
            alu_opcode_q <= alu_opcode_d;
            alu_input1_q <= alu_input1_d;
            alu_input2_q <= alu_input2_d;
            alu_shift_q  <= alu_shift_d;
            tag_q        <= tag_d;
            err_q        <= err_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_tag_q    <= rsp_tag_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign busy           = busy_q;
    assign alu_opcode     = alu_opcode_q;
    assign alu_input1     = alu_input1_q;
    assign alu_input2     = alu_input2_q;
    assign alu_shiftValue = alu_shift_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_result     = rsp_result_q;
    assign rsp_carry      = rsp_carry_q;
    assign rsp_tag        = rsp_tag_q;
    assign rsp_err        = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_cmd_driver
// Purpose  : Self-checking bench for alu_cmd_driver. A behavioural ALU model
//            answers the driver; directed vectors carry hand-computed results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_driver;

    localparam int WIDTH = 128;
    localparam int SHIFT_W = 5;
    localparam int TAG_W = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [3:0]         cmd_opcode = '0;
    logic [WIDTH-1:0]   cmd_a = '0;
    logic [WIDTH-1:0]   cmd_b = '0;
    logic [SHIFT_W-1:0] cmd_shift = '0;
    logic [TAG_W-1:0]   cmd_tag = '0;
    logic [3:0]         alu_opcode;
    logic [WIDTH-1:0]   alu_input1, alu_input2;
    logic [SHIFT_W-1:0] alu_shiftValue;
    logic [WIDTH-1:0]   alu_result;
    logic               alu_carry;
    logic               rsp_valid;
    logic               rsp_ready = 1'b1;
    logic [WIDTH-1:0]   rsp_result;
    logic               rsp_carry;
    logic [TAG_W-1:0]   rsp_tag;
    logic               rsp_err;
    logic               busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_cmd_driver #(
        .WIDTH(WIDTH), .SHIFT_W(SHIFT_W), .TAG_W(TAG_W), .SETTLE(2), .DIV_SETTLE(8)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_shift(cmd_shift), .cmd_tag(cmd_tag),
        .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
        .alu_shiftValue(alu_shiftValue), .alu_result(alu_result), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_carry(rsp_carry), .rsp_tag(rsp_tag), .rsp_err(rsp_err), .busy(busy)
    );

    // Behavioural ALU. Carry is the add overflow / subtract borrow; for other
    // opcodes it is driven high and illegal opcodes return junk, so the
    // driver's masking is visible.
    always_comb begin
        alu_result = '0;
        alu_carry  = 1'b1;
        case (alu_opcode)
            4'd0: {alu_carry, alu_result} = {1'b0, alu_input1} + {1'b0, alu_input2};
            4'd1: {alu_carry, alu_result} = {1'b0, alu_input1} - {1'b0, alu_input2};
            4'd2: alu_result = alu_input1 & alu_input2;
            4'd3: alu_result = alu_input1 | alu_input2;
            4'd4: alu_result = alu_input1 << alu_shiftValue;
            4'd5: alu_result = alu_input1 >> alu_shiftValue;
            4'd6: alu_result = ~(alu_input1 ^ alu_input2);
            4'd7: alu_result = (alu_input2 == '0) ? '0 : alu_input1 / alu_input2;
            default: alu_result = alu_input1 | alu_input2 | 128'hA5;
        endcase
    end

    typedef struct {
        logic [3:0]         op;
        logic [WIDTH-1:0]   a;
        logic [WIDTH-1:0]   b;
        logic [SHIFT_W-1:0] sh;
        logic [TAG_W-1:0]   tag;
        logic [WIDTH-1:0]   exp_res;
        logic               exp_carry;
        logic               exp_err;
        int                 exp_lat;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_cmd(input vec_t v);
        cmd_opcode = v.op;
        cmd_a      = v.a;
        cmd_b      = v.b;
        cmd_shift  = v.sh;
        cmd_tag    = v.tag;
    endtask

    // Waits (bounded) for rsp_valid after the acceptance edge; returns the
    // number of edges from acceptance to visible response.
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int k;
        int lat;
        @(negedge clk);
        drive_cmd(v);
        cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check({name, ".accept_timeout"}, cmd_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check({name, ".alu_in1"}, alu_input1, v.a);
        wait_rsp(lat);
        check({name, ".latency"}, lat, v.exp_lat);
        check({name, ".result"}, rsp_result, v.exp_res);
        check({name, ".carry"}, rsp_carry, v.exp_carry);
        check({name, ".tag"}, rsp_tag, v.tag);
        check({name, ".err"}, rsp_err, v.exp_err);
        @(posedge clk);
        @(negedge clk);
        check({name, ".valid_clear"}, rsp_valid, 1'b0);
        check({name, ".result_kept"}, rsp_result, v.exp_res);
    endtask

    int         rsp_cyc[$];
    logic [3:0] rsp_tags[$];
    int         low_runs[$];

    initial begin
        vec_t v;
        int   lat;
        int   k;
        logic seen;
        int   low_run;
        int   cyc;

        //          op     a                 b          sh     tag    res                carry err lat
        vecs[0]  = '{4'd0, ~128'd0,          128'd1,    5'd0,  4'd3,  128'd0,            1'b1, 1'b0, 2};
        vecs[1]  = '{4'd7, 128'd100,         128'd7,    5'd0,  4'd1,  128'd14,           1'b0, 1'b0, 8};
        vecs[2]  = '{4'd7, 128'd5,           128'd0,    5'd0,  4'd2,  128'd0,            1'b0, 1'b1, 8};
        vecs[3]  = '{4'd9, 128'hFF,          128'h1,    5'd0,  4'd4,  128'd0,            1'b0, 1'b1, 2};
        vecs[4]  = '{4'd2, 128'hF0F0,        128'h0FF0, 5'd0,  4'd5,  128'h00F0,         1'b0, 1'b0, 2};
        vecs[5]  = '{4'd3, 128'hF000,        128'h000F, 5'd0,  4'd6,  128'hF00F,         1'b0, 1'b0, 2};
        vecs[6]  = '{4'd6, 128'd0,           128'd0,    5'd0,  4'd7,  ~128'd0,           1'b0, 1'b0, 2};
        vecs[7]  = '{4'd5, 128'h8000_0000,   128'd0,    5'd4,  4'd8,  128'h0800_0000,    1'b0, 1'b0, 2};
        vecs[8]  = '{4'd1, 128'd3,           128'd5,    5'd0,  4'd10, ~128'd1,           1'b1, 1'b0, 2};
        vecs[9]  = '{4'd0, 128'h1234,        128'h1111, 5'd0,  4'd11, 128'h2345,         1'b0, 1'b0, 2};
        vecs[10] = '{4'd4, 128'd1,           128'd0,    5'd31, 4'd12, 128'h8000_0000,    1'b0, 1'b0, 2};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("reset.cmd_ready", cmd_ready, 1'b0);
        check("reset.rsp_valid", rsp_valid, 1'b0);
        check("reset.busy", busy, 1'b0);
        check("reset.alu_opcode", alu_opcode, 4'd0);
        rst = 1'b0;
        #1;
        check("reset.ready_after_release", cmd_ready, 1'b0);
        @(negedge clk);
        check("reset.ready_first_edge", cmd_ready, 1'b1);

        // Table vectors (the last entry runs after the reset sequence)
        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Response backpressure with a second command held valid
        rsp_ready = 1'b0;
        @(negedge clk);
        v = '{4'd1, 128'd5, 128'd3, 5'd0, 4'd13, 128'd2, 1'b0, 1'b0, 2};
        drive_cmd(v);
        cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        @(negedge clk);
        v = '{4'd0, 128'h10, 128'h20, 5'd3, 4'd9, 128'h30, 1'b0, 1'b0, 2};
        drive_cmd(v);
        wait_rsp(lat);
        check("bp.latency", lat, 2);
        seen = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (rsp_result !== 128'd2 || !rsp_valid || cmd_ready ||
                alu_input1 !== 128'd5 || alu_opcode !== 4'd1) seen = 1'b0;
            @(negedge clk);
        end
        check("bp.held_stable", seen, 1'b1);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp.valid_clear", rsp_valid, 1'b0);
        check("bp.ready_after_hs", cmd_ready, 1'b1);
        check("bp.no_accept_on_hs", alu_input1, 128'd5);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("bp.second_accept_in1", alu_input1, 128'h10);
        check("bp.second_accept_ready", cmd_ready, 1'b0);
        wait_rsp(lat);
        check("bp.second_result", rsp_result, 128'h30);
        check("bp.second_tag", rsp_tag, 4'd9);
        @(posedge clk);
        @(negedge clk);

        // Reset in the middle of a DIV settle window
        @(negedge clk);
        drive_cmd(vecs[1]);
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rstmid.busy_before", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("rstmid.busy", busy, 1'b0);
        check("rstmid.alu_in1", alu_input1, 128'd0);
        check("rstmid.alu_in2", alu_input2, 128'd0);
        check("rstmid.alu_op", alu_opcode, 4'd0);
        check("rstmid.rsp_result", rsp_result, 128'd0);
        check("rstmid.rsp_tag", rsp_tag, 4'd0);
        check("rstmid.cmd_ready", cmd_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("rstmid.no_rsp", seen, 1'b0);
        run_vec(vecs[10], "sll31");

        // Streamed ADD commands with rsp_ready held high
        fork
            begin
                cmd_opcode = 4'd0;
                cmd_a      = 128'd1;
                cmd_b      = 128'd1;
                cmd_tag    = 4'd0;
                cmd_valid  = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    k = 0;
                    while (!cmd_ready && k < 20) begin
                        @(negedge clk);
                        k++;
                    end
                    @(posedge clk);
                    @(negedge clk);
                    if (i == 3) cmd_valid = 1'b0;
                    else cmd_tag = 4'(i + 1);
                end
            end
            begin
                low_run = 0;
                cyc = 0;
                repeat (40) begin
                    @(negedge clk);
                    cyc++;
                    if (rsp_valid) begin
                        rsp_cyc.push_back(cyc);
                        rsp_tags.push_back(rsp_tag);
                    end
                    if (!busy) begin
                        low_run++;
                    end else begin
                        if (low_run > 0 && rsp_cyc.size() > 0) low_runs.push_back(low_run);
                        low_run = 0;
                    end
                end
            end
        join

        check("stream.rsp_count", rsp_cyc.size(), 4);
        check("stream.busy_gaps", low_runs.size(), 3);
        if (rsp_cyc.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("stream.tag%0d", i), rsp_tags[i], 4'(i));
                if (i > 0) check($sformatf("stream.spacing%0d", i),
                                 rsp_cyc[i] - rsp_cyc[i-1], 4);
            end
        end
        for (int i = 0; i < low_runs.size(); i++) begin
            check($sformatf("stream.busy_low%0d", i), low_runs[i], 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_cmd_driver.md
Name: alu_cmd_driver

Overview:
Initiator side of the ALU operand/result interface. Accepts one command at a time over a valid/ready channel, registers the operands, and drives them onto the combinational ALU's opcode/input1/input2/shiftValue inputs. Holds the operands stable for a programmable multicycle settle window, then captures result and carryFlag into a registered response channel with a tag and error flag. It sits between the issuing datapath or sequencer and any ALU instance, so the wide combinational paths (128-bit add and divide) are timed as multicycle paths.

Parameters:
WIDTH, 128, operand/result width
SHIFT_W, 5, shift amount width
TAG_W, 4, command tag width
SETTLE, 2, cycles operands are held before capture for opcodes 0-6; must be >=1
DIV_SETTLE, 8, cycles held before capture for DIV (opcode 7); must be >=SETTLE

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_opcode  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLL, 5 SRL, 6 XNOR, 7 DIV
cmd_a  in  WIDTH  operand 1
cmd_b  in  WIDTH  operand 2
cmd_shift  in  SHIFT_W  shift amount
cmd_tag  in  TAG_W  returned with the response
alu_opcode  out  4  to ALU opcode
alu_input1  out  WIDTH  to ALU input1
alu_input2  out  WIDTH  to ALU input2
alu_shiftValue  out  SHIFT_W  to ALU shiftValue
alu_result  in  WIDTH  from ALU result
alu_carry  in  1  from ALU carryFlag
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when valid&ready
rsp_result  out  WIDTH  captured result
rsp_carry  out  1  captured carry
rsp_tag  out  TAG_W  tag of the command
rsp_err  out  1  DIV with cmd_b==0, or opcode 8-15
busy  out  1  high whenever state != IDLE

Behaviour:
- States: IDLE, SETTLE, RESP. All outputs are registers.
- Reset (async): state IDLE; counter 0; every output, including cmd_ready, rsp_valid and all alu_* and rsp_* buses, is 0. cmd_ready rises on the first clock edge after rst deasserts.
- cmd_ready is 1 only in IDLE.
- IDLE: on cmd_valid&cmd_ready at edge N:
  - load alu_* from cmd_*;
  - latch tag and error condition;
  - load cnt = (opcode==7 ? DIV_SETTLE : SETTLE) - 1;
  - go to SETTLE.
- SETTLE: at each edge, if cnt==0 then capture and go to RESP; otherwise decrement cnt. Capture therefore occurs at edge N+lat, and rsp_valid is visible after that edge.
- Capture rules:
  - rsp_result = alu_result. Forced to 0 for an illegal opcode; 0 for DIV by zero, as returned by the ALU.
  - rsp_carry = alu_carry for opcodes 0/1; 0 otherwise.
  - rsp_err = (opcode==7 && input2==0) || opcode>7.
  - rsp_tag = latched tag.
- An illegal opcode still waits SETTLE cycles (no fast path).
- RESP: rsp_* are held stable while rsp_valid&!rsp_ready. On handshake, rsp_valid goes to 0 and the state returns to IDLE at that edge. No new command is accepted on the same edge.
- Back-to-back throughput: one command per lat+2 cycles.
- alu_* hold their values from acceptance until the next acceptance, through SETTLE and RESP and in IDLE. They never glitch to 0 between commands.
- rsp_* retain their last values after the handshake; only rsp_valid clears.
- cmd_valid while not ready is ignored. No state is taken from cmd_* except at the handshake.
- Reset mid-operation (SETTLE or RESP): the command is dropped, no response is issued, and all outputs are 0 immediately.

Test Plan:
1. SETTLE=2; bench ALU model drives carry on overflow; ADD a=all-ones, b=1, tag=3 -> rsp_valid one cycle after edge N+2; rsp_result=0, rsp_carry=1, rsp_tag=3, rsp_err=0.
2. DIV a=100, b=7 -> rsp_valid after edge N+8; result=14, err=0. Then DIV a=5, b=0 -> result=0, err=1, carry=0.
3. SUB a=5, b=3, with rsp_ready low for 5 cycles and a second cmd_valid held high -> rsp_result=2 stable throughout; cmd_ready=0; alu_* unchanged. Second command accepted exactly 1 edge after the rsp handshake.
4. Opcode 4'd9, a=0xFF, b=0x1 -> after 2 cycles: result=0, err=1, carry=0.
5. rst pulsed mid-way through the DIV SETTLE window -> all outputs 0 asynchronously; no rsp_valid after release. A subsequent SLL a=1, shift=31 returns 0x8000_0000.
6. 4 ADD commands streamed with rsp_ready=1 constant -> responses in order, tags 0-3, spaced 4 cycles apart; busy low for exactly 1 cycle between commands.
